// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: data/strobe widths, response codes and
// the byte-address to register-index mapping.
package axi_lite_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Word index of a byte address; the byte-lane bits are dropped.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr);
        return 32'(addr >> 2);
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register array behind the AXI-Lite slave.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   wr_en_i        commit a write this cycle (index already range-checked)
//   wr_idx_i       register index to write; index 0 is read-only
//   wr_data_i      write data
//   wr_strb_i      byte enables
//   rd_idx_i       register index for the combinational read mux
//   rd_data_c      read data (index 0 returns VERSION)
//   reg_out_o      flattened register contents, reg i at [32i+31:32i]
//   wr_pulse_o     one-cycle pulse per committed write, aligned with the update
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter int unsigned        NUM_REGS = 16,
    parameter logic [DATA_W-1:0]  VERSION  = 32'h0001_0000,
    parameter int unsigned        IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic [STRB_W-1:0]            wr_strb_i,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [DATA_W-1:0]            rd_data_c,
    output logic [DATA_W*NUM_REGS-1:0]   reg_out_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;

    // Strobe-masked write port; register 0 never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_en_i && (wr_idx_i != '0)) begin
                for (int k = 0; k < int'(STRB_W); k++) begin
                    if (wr_strb_i[k]) begin
                        regs_q[wr_idx_i][8*k +: 8] <= wr_data_i[8*k +: 8];
                    end
                end
                wr_pulse_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    // Read mux: the version word lives in the decode, not in storage.
    always_comb begin
        rd_data_c = (rd_idx_i == '0) ? VERSION : regs_q[rd_idx_i];
    end

    always_comb begin
        reg_out_o = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            reg_out_o[DATA_W*i +: DATA_W] = regs_q[i];
        end
    end

    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS 32-bit registers, reg 0 is a
// read-only version word, the rest are read/write with byte strobes.
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   s_axi_aw*/w*/b*      write address / data / response channels
//   s_axi_ar*/r*         read address / data channels
//   reg_out              flattened register contents
//   reg_wr_pulse         one-cycle pulse per committed write to reg i
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned        ADDR_WIDTH = 16,
    parameter int unsigned        NUM_REGS   = 16,
    parameter logic [DATA_W-1:0]  VERSION    = 32'h0001_0000
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_W-1:0]           s_axi_wdata,
    input  logic [STRB_W-1:0]           s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_W-1:0]           s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [DATA_W*NUM_REGS-1:0]  reg_out,
    output logic [NUM_REGS-1:0]         reg_wr_pulse
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic                  w_held_q,  w_held_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    resp_t                 bresp_q,   bresp_d;
    logic                  ar_pend_q, ar_pend_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]     rdata_q,   rdata_d;
    resp_t                 rresp_q,   rresp_d;

    logic [31:0]           aw_idx_c, ar_idx_c;
    logic                  aw_in_range_c, ar_in_range_c;
    logic                  commit_c;
    logic [IDX_W-1:0]      rd_idx_c;
    logic [DATA_W-1:0]     rd_data_c;
    logic                  unused_prot_c;

    assign unused_prot_c = ^{s_axi_awprot, s_axi_arprot};

    assign aw_idx_c      = addr_to_index(32'(awaddr_q));
    assign ar_idx_c      = addr_to_index(32'(araddr_q));
    assign aw_in_range_c = aw_idx_c < 32'(NUM_REGS);
    assign ar_in_range_c = ar_idx_c < 32'(NUM_REGS);
    // Commit only from held state so one write is ever outstanding on B.
    assign commit_c      = aw_held_q && w_held_q && !bvalid_q;
    // Out-of-range reads steer the mux to a safe index; data is zeroed below.
    assign rd_idx_c      = ar_in_range_c ? IDX_W'(ar_idx_c) : '0;

    axi_lite_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .VERSION  (VERSION),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk        (aclk),
        .rst_n      (aresetn),
        .wr_en_i    (commit_c && aw_in_range_c),
        .wr_idx_i   (IDX_W'(aw_idx_c)),
        .wr_data_i  (wdata_q),
        .wr_strb_i  (wstrb_q),
        .rd_idx_i   (rd_idx_c),
        .rd_data_c  (rd_data_c),
        .reg_out_o  (reg_out),
        .wr_pulse_o (reg_wr_pulse)
    );

    // Write path: independent AW/W capture, commit, B response.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (s_axi_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (s_axi_wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (commit_c) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
    end

    // Read path: AR capture, array sample one cycle later, R response.
    always_comb begin
        ar_pend_d = ar_pend_q;
        araddr_d  = araddr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (s_axi_arvalid && arready_q) begin
            ar_pend_d = 1'b1;
            araddr_d  = s_axi_araddr;
        end
        if (ar_pend_q) begin
            ar_pend_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = ar_in_range_c ? rd_data_c : '0;
            rresp_d   = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        arready_d = !(rvalid_d || ar_pend_d);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ar_pend_q <= 1'b0;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ar_pend_q <= ar_pend_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a reference register model
// and response scoreboards.
module tb_axi_lite_reg_slave;
    import axi_lite_pkg::*;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned NUM_REGS   = 16;
    localparam logic [31:0] VERSION    = 32'h0001_0000;
    localparam int unsigned CW         = 32 * NUM_REGS;
    typedef logic [CW-1:0] cv_t;
    typedef struct packed { logic [31:0] data; resp_t resp; } rexp_t;

    logic                  aclk, aresetn;
    logic [ADDR_WIDTH-1:0] s_axi_awaddr, s_axi_araddr;
    logic [2:0]            s_axi_awprot, s_axi_arprot;
    logic                  s_axi_awvalid, s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic [3:0]            s_axi_wstrb;
    logic                  s_axi_wvalid, s_axi_wready;
    logic [1:0]            s_axi_bresp, s_axi_rresp;
    logic                  s_axi_bvalid, s_axi_bready;
    logic                  s_axi_arvalid, s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic                  s_axi_rvalid, s_axi_rready;
    logic [CW-1:0]         reg_out;
    logic [NUM_REGS-1:0]   reg_wr_pulse;

    axi_lite_reg_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .VERSION    (VERSION)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [NUM_REGS];
    int          pulse_cnt [NUM_REGS];
    resp_t       bq [$];
    rexp_t       rq [$];

    always @(negedge aclk) begin
        if (aresetn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (reg_wr_pulse[i]) pulse_cnt[i]++;
            end
        end
    end

    task automatic chk(input string tag, input cv_t obs, input cv_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cv_t model_flat();
        cv_t v = '0;
        for (int i = 1; i < int'(NUM_REGS); i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    function automatic rexp_t exp_read(input logic [ADDR_WIDTH-1:0] addr);
        int unsigned idx = int'(addr) >> 2;
        rexp_t e;
        if (idx >= NUM_REGS) e = '{data: 32'h0, resp: RESP_SLVERR};
        else if (idx == 0)   e = '{data: VERSION, resp: RESP_OKAY};
        else                 e = '{data: model[idx], resp: RESP_OKAY};
        return e;
    endfunction

    // AW leads W by aw_lead cycles; B held b_hold cycles before bready.
    task automatic do_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_lead, input int b_hold,
                            input bit release_b);
        int unsigned idx = int'(addr) >> 2;
        bit aw_pend = 1, w_pend = 1, hs_aw, hs_w;
        int step = 0, lat;
        resp_t e;
        bq.push_back((idx < NUM_REGS) ? RESP_OKAY : RESP_SLVERR);
        if (idx < NUM_REGS && idx != 0) begin
            for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
        end
        @(negedge aclk);
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb;
        while ((aw_pend || w_pend) && step < 50) begin
            if (w_pend && step >= aw_lead) s_axi_wvalid = 1'b1;
            if (!aw_pend && w_pend) chk("awready_low_while_held", cv_t'(s_axi_awready), cv_t'(0));
            hs_aw = aw_pend && s_axi_awready;
            hs_w  = w_pend && s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (hs_aw) begin s_axi_awvalid = 1'b0; aw_pend = 0; end
            if (hs_w)  begin s_axi_wvalid  = 1'b0; w_pend  = 0; end
            @(negedge aclk); step++;
        end
        chk("aw_w_accepted", cv_t'({aw_pend, w_pend}), cv_t'(0));
        lat = 1;
        while (!s_axi_bvalid && lat < 20) begin @(negedge aclk); lat++; end
        chk("b_latency", cv_t'(lat), cv_t'(2));
        e = bq.pop_front();
        chk("bresp", cv_t'(s_axi_bresp), cv_t'(e));
        for (int i = 0; i < b_hold; i++) begin
            @(negedge aclk);
            chk("bvalid_held", cv_t'(s_axi_bvalid), cv_t'(1));
            chk("bresp_stable", cv_t'(s_axi_bresp), cv_t'(e));
        end
        if (release_b) begin
            s_axi_bready = 1'b1;
            @(posedge aclk); #1 s_axi_bready = 1'b0;
            @(negedge aclk);
            chk("bvalid_clear", cv_t'(s_axi_bvalid), cv_t'(0));
        end
    endtask

    task automatic do_read(input logic [ADDR_WIDTH-1:0] addr, input int r_hold,
                           input bit release_r);
        int lat, n = 0;
        bit hs = 0;
        rexp_t e;
        rq.push_back(exp_read(addr));
        @(negedge aclk);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (!hs && n < 50) begin
            hs = s_axi_arready;
            @(posedge aclk); #1;
            if (hs) s_axi_arvalid = 1'b0;
            @(negedge aclk); n++;
        end
        chk("ar_accepted", cv_t'(hs), cv_t'(1));
        lat = 1;
        while (!s_axi_rvalid && lat < 20) begin @(negedge aclk); lat++; end
        chk("r_latency", cv_t'(lat), cv_t'(2));
        e = rq.pop_front();
        chk("rdata", cv_t'(s_axi_rdata), cv_t'(e.data));
        chk("rresp", cv_t'(s_axi_rresp), cv_t'(e.resp));
        for (int i = 0; i < r_hold; i++) begin
            @(negedge aclk);
            chk("rvalid_held", cv_t'(s_axi_rvalid), cv_t'(1));
            chk("rdata_stable", cv_t'(s_axi_rdata), cv_t'(e.data));
        end
        if (release_r) begin
            s_axi_rready = 1'b1;
            @(posedge aclk); #1 s_axi_rready = 1'b0;
            @(negedge aclk);
            chk("rvalid_clear", cv_t'(s_axi_rvalid), cv_t'(0));
        end
    endtask

    task automatic apply_reset();
        @(negedge aclk); #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
        chk("rst_bvalid", cv_t'(s_axi_bvalid), cv_t'(0));
        chk("rst_rvalid", cv_t'(s_axi_rvalid), cv_t'(0));
        chk("rst_rdata", cv_t'(s_axi_rdata), cv_t'(0));
        chk("rst_reg_out", reg_out, cv_t'(0));
        @(negedge aclk); aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_readies", cv_t'({s_axi_awready, s_axi_wready, s_axi_arready}), cv_t'(3'b111));
    endtask

    initial begin
        int p0, p1;
        logic [ADDR_WIDTH-1:0] ra;
        aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin model[i] = '0; pulse_cnt[i] = 0; end

        // Reset state
        #2;
        chk("reset_readies", cv_t'({s_axi_awready, s_axi_wready, s_axi_arready}), cv_t'(0));
        chk("reset_valids", cv_t'({s_axi_bvalid, s_axi_rvalid}), cv_t'(0));
        chk("reset_resps", cv_t'({s_axi_bresp, s_axi_rresp, s_axi_rdata}), cv_t'(0));
        chk("reset_reg_out", reg_out, cv_t'(0));
        chk("reset_pulse", cv_t'(reg_wr_pulse), cv_t'(0));
        repeat (3) @(negedge aclk);
        chk("reset_awready_held", cv_t'(s_axi_awready), cv_t'(0));
        aresetn = 1'b1;
        @(negedge aclk);
        chk("readies_after_release", cv_t'({s_axi_awready, s_axi_wready, s_axi_arready}), cv_t'(3'b111));

        // Version word
        do_read(16'h0000, 0, 1);

        // Full write then readback, one pulse on reg 1
        do_write(16'h0004, 32'h1234_5678, 4'hF, 0, 0, 1);
        chk("pulse_reg1_once", cv_t'(pulse_cnt[1]), cv_t'(1));
        chk("reg_out_after_w1", reg_out, model_flat());
        do_read(16'h0004, 0, 1);

        // Partial strobe write
        do_write(16'h0004, 32'hAABB_CCDD, 4'h3, 0, 0, 1);
        chk("reg1_partial", cv_t'(reg_out[63:32]), cv_t'(32'h1234_CCDD));
        do_read(16'h0004, 0, 1);

        // Write to read-only reg 0
        p0 = pulse_cnt[0];
        do_write(16'h0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
        do_read(16'h0000, 0, 1);
        chk("no_pulse_reg0", cv_t'(pulse_cnt[0]), cv_t'(p0));
        chk("reg_out_after_w0", reg_out, model_flat());

        // AW leads W by 5 cycles, bready held off 10 cycles
        do_write(16'h0008, 32'h5A5A_5A5A, 4'hF, 5, 10, 1);
        do_read(16'h0008, 3, 1);
        chk("reg2_value", cv_t'(reg_out[95:64]), cv_t'(32'h5A5A_5A5A));

        // Out of range
        p1 = pulse_cnt[1];
        do_write(16'h0100, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
        do_read(16'h0100, 0, 1);
        chk("oor_reg_out", reg_out, model_flat());
        chk("oor_no_pulse", cv_t'(pulse_cnt[1]), cv_t'(p1));

        // Reset while B is outstanding
        do_write(16'h000C, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        apply_reset();
        do_write(16'h0010, 32'h0BAD_F00D, 4'hF, 0, 0, 1);
        // Reset while R is outstanding
        do_read(16'h0010, 0, 0);
        apply_reset();
        do_write(16'h0014, 32'h1111_2222, 4'hF, 0, 0, 1);
        do_read(16'h0014, 0, 1);
        do_read(16'h0010, 0, 1);
        chk("reg_out_after_resets", reg_out, model_flat());

        // Mixed random traffic against the model
        for (int i = 0; i < 8; i++) begin
            ra = ADDR_WIDTH'($urandom_range(0, NUM_REGS + 3) * 4);
            do_write(ra, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1);
            do_read(ra, 0, 1);
            chk("rand_reg_out", reg_out, model_flat());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder (slave) exposing a bank of 32-bit control/status registers to the host-side AXI master.
- Sits behind the interconnect; the testbench VIP master's single-beat INCR reads and writes land here.
- Register contents drive fabric logic through a flattened output bus with per-register write pulses.
- Register 0 is a read-only version word; all others are read/write.

Parameters:
ADDR_WIDTH, 16, byte-address width of AW/AR channels
NUM_REGS, 16, number of 32-bit registers (2..256); register i at byte offset 4*i
VERSION, 32'h0001_0000, value returned by register 0

Ports:
aclk  in  1  clock
aresetn  in  1  reset (asynchronous, active-low)
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read valid
s_axi_rready  in  1  read ready
reg_out  out  32*NUM_REGS  register contents, reg i at bits [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on each committed write to reg i

Behaviour:
Reset (aresetn low, async):
- All valid/ready outputs are 0; bresp, rresp and rdata are 0; reg_out is 0 (reg 0 reads VERSION regardless); reg_wr_pulse is 0; held-address/data flags are cleared.
- The ready outputs rise on the first aclk edge after release.

Address decoding:
- index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- index >= NUM_REGS -> out of range -> SLVERR (2'b10); otherwise OKAY (2'b00).

Write path (registered readies):
- awready = !aw_held; wready = !w_held. An AW or W handshake captures addr or data+strb and sets the corresponding held flag.
- AW and W are accepted independently and in any order, including the same cycle.
- Commit happens in the cycle where both are held (or both handshake) and bvalid is 0:
  - in-range index != 0: byte lanes with wstrb[k]=1 update; reg_wr_pulse[index]=1 for one cycle;
  - index 0: write ignored, OKAY returned;
  - out of range: no update, SLVERR.
- On commit the held flags clear, bvalid is set and bresp is loaded. Minimum latency is AW+W handshake at edge N -> bvalid high after edge N+1.
- bvalid stays high with bresp stable until bready; it clears on that handshake.
- While bvalid is high no new commit occurs, but one AW and one W may still be captured and held. This gives at most one write outstanding.

Read path:
- arready = !rvalid (registered). An AR handshake at edge N samples the register array and presents rdata/rresp with rvalid high after edge N+1.
- Out-of-range reads return rdata=0 with SLVERR.
- rvalid, rdata and rresp are held stable until rready; the handshake clears rvalid and re-enables arready.

Simultaneous events:
- A read and a commit to the same register at the same edge: the read returns the old value.
- Read and write paths are fully independent.

Reset mid-operation:
- Any held or outstanding transaction is discarded and no B or R response is issued.
- Registers return to 0.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants, a typedef for the 2-bit response, and an addr-to-index function.
- One natural sub-module, axi_lite_reg_bank: the register array with strobe-masked writes, a synchronous write port and an asynchronous read mux.
- The AXI handshake logic stays in the top module.

Test Plan:
- Read 0x0 after reset -> rdata=VERSION (32'h0001_0000), rresp=OKAY, rvalid one cycle after AR handshake.
- Write 0x4 data 32'h12345678 wstrb 4'hF, then read 0x4 -> bresp=OKAY, rdata=32'h12345678, reg_wr_pulse[1] pulses once.
- Write 0x4 data 32'hAABBCCDD wstrb 4'h3 over 32'h12345678 -> readback 32'h1234CCDD; write 32'hFFFFFFFF to 0x0 -> bresp OKAY, readback still VERSION.
- AW for 0x8 presented 5 cycles before W (data 32'h5A5A5A5A), with bready held low 10 cycles -> awready drops after capture, bvalid/bresp stable until bready, then readback 32'h5A5A5A5A.
- Write and read 0x100 with NUM_REGS=16 -> bresp=SLVERR, rresp=SLVERR, rdata=0, no reg_out change.
- Assert aresetn low while bvalid=1 and while rvalid=1 -> all valids drop immediately, reg_out=0, next transactions complete normally.
